// File: rtl/dmem_loader.sv
// ---------------------------------------------------------------------------
// dmem_loader
//
// Loads a data memory image from a byte stream into the init port of a
// (possibly cached) data memory. The stream begins with a 4-byte
// little-endian word count N, followed by N little-endian payload words.
// Each assembled word is presented as one full-word init write at
// BASE_ADDR + 4*index and held until the downstream memory accepts it
// (i_stall low). A running mod-2^32 checksum of accepted words is kept.
// A header with N == 0 finishes the load immediately; a header with
// N > MAX_WORDS aborts the load with o_error.
//
// Ports
//   i_clk        clock; every state change happens on its rising edge
//   i_rst        synchronous active-high reset
//   i_rx_valid   byte-stream valid
//   i_rx_data    byte-stream data
//   o_rx_ready   byte-stream ready (transfer when valid & ready)
//   i_stall      downstream stall; a write is accepted when wen!=0 & !stall
//   o_init_wen   init write byte enables (4'b1111 while writing)
//   o_init_addr  init write byte address
//   o_init_data  init write data
//   o_init_done  load complete, held until reset
//   o_error      header rejected, load aborted, held until reset
//   o_checksum   mod-2^32 sum of all words accepted downstream
// ---------------------------------------------------------------------------
module dmem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] MAX_WORDS = 32'h0010_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_rx_valid,
    input  logic [7:0]  i_rx_data,
    output logic        o_rx_ready,
    input  logic        i_stall,
    output logic [3:0]  o_init_wen,
    output logic [31:0] o_init_addr,
    output logic [31:0] o_init_data,
    output logic        o_init_done,
    output logic        o_error,
    output logic [31:0] o_checksum
);

    typedef enum logic [2:0] {
        S_HDR,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [1:0]  byte_cnt;
    logic [31:0] word_buf;
    logic [31:0] word_full;
    logic [31:0] n_words;
    logic [31:0] word_idx;
    logic [31:0] idx_next;
    logic [31:0] init_addr;
    logic [31:0] init_data;
    logic [31:0] checksum;
    logic        rx_fire;
    logic        write_fire;
    logic        last_byte;

    // Bytes arrive least-significant first, so each new byte is shifted in
    // at the top; after four bytes the first one sits in bits 7:0.
    assign word_full  = {i_rx_data, word_buf[31:8]};
    assign last_byte  = (byte_cnt == 2'd3);
    assign idx_next   = word_idx + 32'd1;
    assign rx_fire    = i_rx_valid && o_rx_ready;
    assign write_fire = (state == S_WRITE) && !i_stall;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of block order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_HDR;
        end else begin
            state <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and output decode
    // -----------------------------------------------------------------------
    // NOTE: every output of this block is given a default first so that no
    // path through the case statement leaves one unassigned (no latches).
    always_comb begin
        state_next  = state;
        o_rx_ready  = 1'b0;
        o_init_wen  = 4'b0000;
        o_init_done = 1'b0;
        o_error     = 1'b0;

        case (state)
            S_HDR: begin
                o_rx_ready = 1'b1;
                if (i_rx_valid && last_byte) begin
                    if (word_full == 32'd0) begin
                        state_next = S_DONE;
                    end else if (word_full > MAX_WORDS) begin
                        state_next = S_ERROR;
                    end else begin
                        state_next = S_DATA;
                    end
                end
            end

            S_DATA: begin
                o_rx_ready = 1'b1;
                if (i_rx_valid && last_byte) begin
                    state_next = S_WRITE;
                end
            end

            S_WRITE: begin
                o_init_wen = 4'b1111;
                if (!i_stall) begin
                    state_next = (idx_next == n_words) ? S_DONE : S_DATA;
                end
            end

            S_DONE: begin
                o_init_done = 1'b1;
            end

            S_ERROR: begin
                o_error = 1'b1;
            end

            default: begin
                state_next = S_HDR;
            end
        endcase

        // While reset is asserted the block presents an idle interface, so a
        // write that was pending when reset arrived is never accepted.
        if (i_rst) begin
            o_rx_ready  = 1'b0;
            o_init_wen  = 4'b0000;
            o_init_done = 1'b0;
            o_error     = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Datapath: byte assembly, write address/data, index and checksum
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            byte_cnt <= 2'd0;
            word_buf <= 32'd0;
            n_words  <= 32'd0;
            word_idx <= 32'd0;
            checksum <= 32'd0;
        end else begin
            if (rx_fire) begin
                byte_cnt <= byte_cnt + 2'd1;
                word_buf <= word_full;
                if (last_byte && (state == S_HDR)) begin
                    n_words <= word_full;
                end
                if (last_byte && (state == S_DATA)) begin
                    init_data <= word_full;
                    init_addr <= BASE_ADDR + {word_idx[29:0], 2'b00};
                end
            end
            if (write_fire) begin
                word_idx <= idx_next;
                checksum <= checksum + init_data;
            end
        end
    end
    // NOTE: init_addr/init_data are deliberately left out of reset: they only
    // matter while o_init_wen is high and must change only on entry to WRITE.

    assign o_init_addr = init_addr;
    assign o_init_data = init_data;
    assign o_checksum  = checksum;

endmodule

// File: doc/dmem_loader.md
DMEM_LOADER -- requirements
Module: m_dmem_loader

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000: byte address of the first word written.
REQ-002 Parameter MAX_WORDS, default 32'h0010_0000: largest accepted word count.
REQ-003 i_clk  in  1  single clock; all state changes on its rising edge.
REQ-004 i_rst  in  1  reset; synchronous, active-high.
REQ-005 i_rx_valid  in  1  byte-stream valid.
REQ-006 i_rx_data  in  8  byte-stream data.
REQ-007 o_rx_ready  out  1  byte-stream ready; a byte transfers on a cycle with i_rx_valid=1 and o_rx_ready=1.
REQ-008 i_stall  in  1  downstream stall (cached-memory stall); a write is accepted on a cycle with o_init_wen!=0 and i_stall=0.
REQ-009 o_init_wen  out  4  init write byte enables, drives downstream i_dmem_init_wen.
REQ-010 o_init_addr  out  32  init write byte address, drives i_dmem_init_addr.
REQ-011 o_init_data  out  32  init write data, drives i_dmem_init_data.
REQ-012 o_init_done  out  1  load complete, drives i_dmem_init_done.
REQ-013 o_error  out  1  header rejected; load aborted.
REQ-014 o_checksum  out  32  mod-2^32 sum of all words accepted downstream.

Function
REQ-015 Stream format SHALL be: 4-byte little-endian word count N, then 4*N payload bytes, each word little-endian (first byte -> bits 7:0).
REQ-016 States SHALL be HDR, DATA, WRITE, DONE, ERROR; reset state HDR.
REQ-017 HDR: o_rx_ready=1; 2-bit byte counter assembles N; on the 4th byte: N==0 -> DONE, N>MAX_WORDS -> ERROR, else -> DATA.
REQ-018 DATA: o_rx_ready=1; byte counter assembles a word; on the 4th byte -> WRITE next cycle.
REQ-019 WRITE: o_rx_ready=0; o_init_wen=4'b1111, o_init_addr=BASE_ADDR+{word_idx,2'b00}, o_init_data=assembled word, all held stable while i_stall=1.
REQ-020 WRITE acceptance (i_stall=0): word_idx+1, o_checksum+=word; if word_idx+1==N -> DONE, else -> DATA.
REQ-021 Latency: word's 4th byte accepted on cycle t -> o_init_wen asserted on cycle t+1; with i_stall=0 the next byte is accepted no earlier than t+2.
REQ-022 o_init_wen SHALL be 4'b0000 in every state except WRITE; o_init_addr/o_init_data are don't-care when wen=0 but SHALL not change except on state entry to WRITE.
REQ-023 DONE: o_init_done=1 held until reset; o_rx_ready=0; further bytes ignored.
REQ-024 ERROR: o_error=1 held until reset; o_init_done=0; o_rx_ready=0; no writes.
REQ-025 i_rx_valid=0 mid-word SHALL pause assembly without losing partial bytes; no timeout.
REQ-026 Address arithmetic SHALL be 32-bit wrap-around; word_idx SHALL be 32 bits.
REQ-027 i_rx_valid high during WRITE SHALL not be consumed (ready low); the byte remains pending.

Reset
REQ-028 On i_rst=1 at a clock edge: state HDR, counters, word_idx, N, partial word and o_checksum = 0; o_init_wen=0, o_init_done=0, o_error=0, o_rx_ready=0 during reset cycle, 1 on the first cycle after.
REQ-029 Reset mid-WRITE SHALL drop the pending write (o_init_wen=0 the next cycle); a partially assembled word is discarded.

Verification
REQ-030 Bytes 02 00 00 00 | 78 56 34 12 | EF BE AD DE, i_stall=0 -> writes (0x0000_0000, 0x1234_5678) then (0x0000_0004, 0xDEAD_BEEF), wen=4'hF, o_init_done=1 the cycle after the second write, o_checksum=0xF0E2_1567.
REQ-031 Same stream, i_stall=1 for 5 cycles during first WRITE -> addr/data/wen stable for 5 cycles, o_rx_ready=0, exactly one write accepted, final results as REQ-030.
REQ-032 Header 00 00 00 00 -> o_init_done=1 the cycle after the 4th byte; no write ever issued; o_checksum=0.
REQ-033 MAX_WORDS=4, header 05 00 00 00 -> o_error=1, o_init_done=0, o_rx_ready=0, no writes; subsequent bytes ignored.
REQ-034 BASE_ADDR=0x100, N=1, i_rx_valid toggled 1/0 every cycle -> single write at 0x100 with correctly assembled data.
REQ-035 i_rst pulsed after 2 payload bytes, then full REQ-030 stream -> identical results to REQ-030, no write from the aborted word.
